// File: rtl/pmac_pkg.sv
// Shared definitions for the windowed multiply-accumulate unit: window length
// clamp, pipeline stage indices, rounding constant and output saturation bounds.
package pmac_pkg;

  // Pipeline stage indices, counted from the edge a beat is accepted
  localparam int STG_S1 = 1;
  localparam int STG_S2 = 2;
  localparam int STG_S3 = 3;
  localparam int STG_S4 = 4;

  // Length 0 behaves as a single-product window; oversize lengths clamp to max
  function automatic int unsigned eff_len(input int unsigned len,
                                          input int unsigned max_len);
    if (len == 0) return 1;
    else if (len > max_len) return max_len;
    else return len;
  endfunction

  // Half an output LSB in accumulator scaling
  function automatic longint round_const(input int frac_bits);
    return (frac_bits > 0) ? (64'sd1 <<< (frac_bits - 1)) : 64'sd0;
  endfunction

  function automatic longint sat_max(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/pmac_window_unit_if.sv
// Beat/result bus of the windowed MAC. The fetch side drives the master end,
// the MAC unit sits on the slave end.
interface pmac_window_unit_if #(
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 16,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] md;
  logic signed [DATA_W-1:0] mr;
  logic [LEN_W-1:0]         len;
  logic signed [DATA_W-1:0] bias;
  logic                     relu_en;
  logic                     round_en;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  out_data;
  logic                     sat_flag;
  logic                     busy;

  modport master (
    output in_valid, md, mr, len, bias, relu_en, round_en,
    input  out_valid, out_data, sat_flag, busy
  );

  modport slave (
    input  in_valid, md, mr, len, bias, relu_en, round_en,
    output out_valid, out_data, sat_flag, busy
  );
endinterface

// File: rtl/pmac_booth_mult.sv
// Combinational signed radix-4 Booth multiplier. Partial products are reduced
// by a 3:2 carry-save tree down to two rows, then one carry-propagate add.
module pmac_booth_mult #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0]   md_i,
  input  logic signed [DATA_W-1:0]   mr_i,
  output logic signed [2*DATA_W-1:0] prod_o
);
  localparam int PW  = 2 * DATA_W;
  localparam int MW  = DATA_W + (DATA_W % 2);
  localparam int NPP = MW / 2;

  // Row count after a given number of 3:2 reduction levels
  function automatic int csa_cnt(input int n0, input int lvl);
    int n;
    n = n0;
    for (int i = 0; i < lvl; i++)
      if (n > 2) n = 2 * (n / 3) + (n % 3);
    return n;
  endfunction

  function automatic int csa_lvls(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = 2 * (n / 3) + (n % 3);
      l++;
    end
    return l;
  endfunction

  localparam int LVLS = csa_lvls(NPP);

  logic [MW:0]    mrx;
  logic [PW-1:0]  mde;
  logic [PW-1:0]  tree [LVLS+1][NPP];

  assign mrx = {MW'(mr_i), 1'b0};
  assign mde = PW'(md_i);

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    logic [2:0]    sel;
    logic [PW-1:0] mag;
    assign sel = mrx[2*i+2 -: 3];
    // Booth digit selects 0, +-md or +-2md
    always_comb begin
      case (sel)
        3'b001, 3'b010: mag = mde;
        3'b011:         mag = mde << 1;
        3'b100:         mag = -(mde << 1);
        3'b101, 3'b110: mag = -mde;
        default:        mag = '0;
      endcase
    end
    assign tree[0][i] = mag << (2 * i);
  end

  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int N  = csa_cnt(NPP, l);
    localparam int G  = N / 3;
    localparam int NN = csa_cnt(NPP, l + 1);
    for (genvar g = 0; g < G; g++) begin : g_csa
      assign tree[l+1][2*g]   = tree[l][3*g] ^ tree[l][3*g+1] ^ tree[l][3*g+2];
      assign tree[l+1][2*g+1] = ((tree[l][3*g]   & tree[l][3*g+1]) |
                                 (tree[l][3*g]   & tree[l][3*g+2]) |
                                 (tree[l][3*g+1] & tree[l][3*g+2])) << 1;
    end
    for (genvar k = 0; k < N % 3; k++) begin : g_pass
      assign tree[l+1][2*G+k] = tree[l][3*G+k];
    end
    for (genvar k = NN; k < NPP; k++) begin : g_zero
      assign tree[l+1][k] = '0;
    end
  end

  assign prod_o = signed'(tree[LVLS][0] + tree[LVLS][1]);

endmodule

// File: rtl/pmac_window_unit.sv
// Pipelined signed fixed-point MAC over a runtime-programmable window, with
// bias preload, optional round-half-up, optional ReLU and output saturation.
module pmac_window_unit
  import pmac_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int OUT_W     = 16,
  parameter int MAX_LEN   = 256,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input logic               clk,
  input logic               rst,
  pmac_window_unit_if.slave bus
);
  localparam logic signed [ACC_W-1:0] RND_C  = ACC_W'(round_const(FRAC_BITS));
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(OUT_W));

  // Round, shift, ReLU, saturate; result is {clamped, data}
  function automatic logic [OUT_W:0] post_proc(input logic signed [ACC_W-1:0] acc,
                                               input logic rnd, input logic relu);
    logic signed [ACC_W-1:0] v;
    v = rnd ? acc + RND_C : acc;
    v = v >>> FRAC_BITS;
    if (relu && v[ACC_W-1]) v = '0;
    if (v > SAT_HI) return {1'b1, SAT_HI[OUT_W-1:0]};
    if (v < SAT_LO) return {1'b1, SAT_LO[OUT_W-1:0]};
    return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic                       vld_p0_q, relu_p0_q, round_p0_q;
  logic signed [DATA_W-1:0]   md_p0_q, mr_p0_q, bias_p0_q;
  logic [LEN_W-1:0]           len_p0_q;

  logic [LEN_W-1:0]           cnt_q, cnt_d, sh_len_q, sh_len_d, win_len;
  logic                       sh_relu_q, sh_relu_d, sh_round_q, sh_round_d;
  logic                       first_w, last_w;

  logic                       vld_p1_q, first_p1_q, last_p1_q, relu_p1_q, round_p1_q;
  logic signed [DATA_W-1:0]   md_p1_q, mr_p1_q, bias_p1_q;

  logic signed [2*DATA_W-1:0] prod_d, prod_p2_q;
  logic                       vld_p2_q, first_p2_q, last_p2_q, relu_p2_q, round_p2_q;
  logic signed [DATA_W-1:0]   bias_p2_q;

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       vld_p3_q, last_p3_q, relu_p3_q, round_p3_q;

  logic [OUT_W:0]             pp_w;
  logic                       fire_w;
  logic                       out_valid_q, sat_q;
  logic signed [OUT_W-1:0]    out_data_q;

  // Input capture: raw beat and its sideband
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p0_q   <= 1'b0;
      md_p0_q    <= '0;
      mr_p0_q    <= '0;
      bias_p0_q  <= '0;
      len_p0_q   <= '0;
      relu_p0_q  <= 1'b0;
      round_p0_q <= 1'b0;
    end else begin
      vld_p0_q   <= bus.in_valid;
      md_p0_q    <= bus.md;
      mr_p0_q    <= bus.mr;
      bias_p0_q  <= bus.bias;
      len_p0_q   <= bus.len;
      relu_p0_q  <= bus.relu_en;
      round_p0_q <= bus.round_en;
    end
  end

  // Beat tagging: first beat uses live config, later beats use the shadow
  always_comb begin
    first_w    = (cnt_q == '0);
    win_len    = first_w ? LEN_W'(eff_len(32'(len_p0_q), MAX_LEN)) : sh_len_q;
    last_w     = (cnt_q == win_len - LEN_W'(1));
    cnt_d      = cnt_q;
    sh_len_d   = sh_len_q;
    sh_relu_d  = sh_relu_q;
    sh_round_d = sh_round_q;
    if (vld_p0_q) begin
      cnt_d = last_w ? '0 : cnt_q + LEN_W'(1);
      if (first_w) begin
        sh_len_d   = win_len;
        sh_relu_d  = relu_p0_q;
        sh_round_d = round_p0_q;
      end
    end
  end

  // ---- S1: operands, tags and window config registered ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      sh_len_q   <= '0;
      sh_relu_q  <= 1'b0;
      sh_round_q <= 1'b0;
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
      relu_p1_q  <= 1'b0;
      round_p1_q <= 1'b0;
      md_p1_q    <= '0;
      mr_p1_q    <= '0;
      bias_p1_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      sh_len_q   <= sh_len_d;
      sh_relu_q  <= sh_relu_d;
      sh_round_q <= sh_round_d;
      vld_p1_q   <= vld_p0_q;
      first_p1_q <= first_w;
      last_p1_q  <= last_w;
      relu_p1_q  <= first_w ? relu_p0_q : sh_relu_q;
      round_p1_q <= first_w ? round_p0_q : sh_round_q;
      md_p1_q    <= md_p0_q;
      mr_p1_q    <= mr_p0_q;
      bias_p1_q  <= bias_p0_q;
    end
  end

  pmac_booth_mult #(.DATA_W(DATA_W)) u_mult (
    .md_i   (md_p1_q),
    .mr_i   (mr_p1_q),
    .prod_o (prod_d)
  );

  // ---- S2: full-width product registered ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p2_q   <= 1'b0;
      first_p2_q <= 1'b0;
      last_p2_q  <= 1'b0;
      relu_p2_q  <= 1'b0;
      round_p2_q <= 1'b0;
      prod_p2_q  <= '0;
      bias_p2_q  <= '0;
    end else begin
      vld_p2_q   <= vld_p1_q;
      first_p2_q <= first_p1_q;
      last_p2_q  <= last_p1_q;
      relu_p2_q  <= relu_p1_q;
      round_p2_q <= round_p1_q;
      prod_p2_q  <= prod_d;
      bias_p2_q  <= bias_p1_q;
    end
  end

  // First beat restarts from the aligned bias; bubbles hold the accumulator
  always_comb begin
    acc_d = acc_q;
    if (vld_p2_q) begin
      if (first_p2_q) acc_d = ACC_W'(prod_p2_q) + (ACC_W'(bias_p2_q) <<< FRAC_BITS);
      else            acc_d = acc_q + ACC_W'(prod_p2_q);
    end
  end

  // ---- S3: accumulate ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q      <= '0;
      vld_p3_q   <= 1'b0;
      last_p3_q  <= 1'b0;
      relu_p3_q  <= 1'b0;
      round_p3_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      vld_p3_q   <= vld_p2_q;
      last_p3_q  <= last_p2_q;
      relu_p3_q  <= relu_p2_q;
      round_p3_q <= round_p2_q;
    end
  end

  // Post-processing of the completed window
  always_comb begin
    fire_w = vld_p3_q & last_p3_q;
    pp_w   = post_proc(acc_q, round_p3_q, relu_p3_q);
  end

  // ---- S4: result register; data holds between pulses ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= fire_w;
      sat_q       <= fire_w & pp_w[OUT_W];
      if (fire_w) out_data_q <= pp_w[OUT_W-1:0];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.sat_flag  = sat_q;
  assign bus.busy      = (cnt_q != '0) | vld_p0_q | vld_p1_q | vld_p2_q | vld_p3_q;

endmodule

// File: tb/tb_pmac_window_unit.sv
// Directed bench for pmac_window_unit: hand-computed Q8.8 windows.
module tb_pmac_window_unit;
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;
  localparam int OUT_W     = 16;
  localparam int MAX_LEN   = 256;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pmac_window_unit_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .MAX_LEN(MAX_LEN),
                        .LEN_W(LEN_W)) bus ();

  pmac_window_unit #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W),
                     .OUT_W(OUT_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sat_idle_err = 0;
  int last_drive = 0;
  int lc;
  logic [15:0] q_data[$];
  logic        q_sat[$];
  int          q_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor, sampled shortly after each edge
  always @(posedge clk) begin
    #2;
    if (bus.out_valid) begin
      q_data.push_back(bus.out_data);
      q_sat.push_back(bus.sat_flag);
      q_cyc.push_back(cyc);
    end else if (bus.sat_flag) begin
      sat_idle_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] res_data(input int i);
    return (i < q_data.size()) ? 32'(q_data[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] res_sat(input int i);
    return (i < q_sat.size()) ? 32'(q_sat[i]) : 32'hDEAD_BEEF;
  endfunction
  function automatic logic [31:0] res_cyc(input int i);
    return (i < q_cyc.size()) ? 32'(q_cyc[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic clr();
    q_data.delete();
    q_sat.delete();
    q_cyc.delete();
  endtask

  // Drive one beat at a falling edge; in_valid stays up for back-to-back calls
  task automatic beat(input logic [15:0] md, input logic [15:0] mr,
                      input logic [LEN_W-1:0] len, input logic [15:0] bias,
                      input logic relu, input logic rnd);
    bus.in_valid = 1'b1;
    bus.md       = md;
    bus.mr       = mr;
    bus.len      = len;
    bus.bias     = bias;
    bus.relu_en  = relu;
    bus.round_en = rnd;
    last_drive   = cyc;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.md = '0; bus.mr = '0; bus.len = '0; bus.bias = '0;
    bus.relu_en = 1'b0; bus.round_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data), 0);
    chk("rst_sat",       32'(bus.sat_flag), 0);
    chk("rst_busy",      32'(bus.busy), 0);
    rst = 1'b1;
    @(negedge clk);

    // len=3, bias 0.5, three beats of 1.0*2.0 -> 6.5
    clr();
    beat(16'h0100, 16'h0200, 3, 16'h0080, 0, 0);
    chk("t1_busy_mid", 32'(bus.busy), 1);
    beat(16'h0100, 16'h0200, 3, 16'h0080, 0, 0);
    beat(16'h0100, 16'h0200, 3, 16'h0080, 0, 0);
    lc = last_drive;
    idle(8);
    chk("t1_count", 32'(q_data.size()), 1);
    chk("t1_data",  res_data(0), 32'h0680);
    chk("t1_sat",   res_sat(0), 0);
    chk("t1_lat",   res_cyc(0) - 32'(lc + 1), 4);
    chk("t1_busy_end", 32'(bus.busy), 0);
    chk("t1_hold",  32'(bus.out_data), 32'h0680);

    // len=1 rounding on/off, back-to-back single-beat windows
    clr();
    beat(16'h0001, 16'h0080, 1, 16'h0000, 0, 1);
    beat(16'h0001, 16'h0080, 1, 16'h0000, 0, 0);
    idle(8);
    chk("t2_count", 32'(q_data.size()), 2);
    chk("t2_rnd1",  res_data(0), 32'h0001);
    chk("t2_rnd0",  res_data(1), 32'h0000);
    chk("t2_gap",   res_cyc(1) - res_cyc(0), 1);

    // ReLU on/off with a negative result
    clr();
    beat(16'hFF00, 16'h0100, 1, 16'h0000, 1, 0);
    beat(16'hFF00, 16'h0100, 1, 16'h0000, 0, 0);
    idle(8);
    chk("t3_count",  32'(q_data.size()), 2);
    chk("t3_relu1",  res_data(0), 32'h0000);
    chk("t3_relu0",  res_data(1), 32'hFF00);
    chk("t3_sat",    res_sat(1), 0);

    // Positive and negative saturation
    clr();
    repeat (4) beat(16'h7FFF, 16'h7FFF, 4, 16'h0000, 0, 0);
    repeat (4) beat(16'h8001, 16'h7FFF, 4, 16'h0000, 0, 0);
    idle(8);
    chk("t4_count",   32'(q_data.size()), 2);
    chk("t4_pos",     res_data(0), 32'h7FFF);
    chk("t4_pos_sat", res_sat(0), 1);
    chk("t4_neg",     res_data(1), 32'h8000);
    chk("t4_neg_sat", res_sat(1), 1);

    // Bubble in window 1, window 2 follows immediately with its own bias
    clr();
    beat(16'h0100, 16'h0100, 2, 16'h0000, 0, 0);
    idle(1);
    beat(16'h0100, 16'h0100, 2, 16'h0000, 0, 0);
    beat(16'h0100, 16'h0100, 2, 16'h0100, 0, 0);
    beat(16'h0100, 16'h0100, 2, 16'h0100, 0, 0);
    idle(8);
    chk("t5_count", 32'(q_data.size()), 2);
    chk("t5_w1",    res_data(0), 32'h0200);
    chk("t5_w2",    res_data(1), 32'h0300);
    chk("t5_gap",   res_cyc(1) - res_cyc(0), 2);

    // len=0 behaves as a one-beat window
    clr();
    beat(16'h0100, 16'h0100, 0, 16'h0000, 0, 0);
    idle(8);
    chk("t6_count", 32'(q_data.size()), 1);
    chk("t6_data",  res_data(0), 32'h0100);

    // Reset mid-window discards the partial window
    clr();
    repeat (3) beat(16'h0100, 16'h0100, 5, 16'h0000, 0, 0);
    chk("t7_busy_pre", 32'(bus.busy), 1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("t7_busy_rst", 32'(bus.busy), 0);
    repeat (5) beat(16'h0100, 16'h0100, 5, 16'h0000, 0, 0);
    idle(3);
    chk("t7_ov_pre", 32'(bus.out_valid), 0);
    idle(1);
    chk("t7_ov",     32'(bus.out_valid), 1);
    chk("t7_busy0",  32'(bus.busy), 0);
    idle(1);
    chk("t7_busy1",  32'(bus.busy), 0);
    idle(4);
    chk("t7_count",  32'(q_data.size()), 1);
    chk("t7_data",   res_data(0), 32'h0500);

    chk("sat_idle", 32'(sat_idle_err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
